// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: running-compare encoding,
// controller FSM states and the single-bit cell rule.
package cmp_pkg;

   typedef enum logic [1:0] {
      EQ = 2'b00,
      GT = 2'b01,
      LT = 2'b10
   } cmp_state_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } fsm_state_e;

   // Bits arrive LSB first, so a differing bit always overrides what came before it.
   function automatic cmp_state_e cell_next(input logic a, input logic b, input cmp_state_e x);
      if (a && !b) return GT;
      if (!a && b) return LT;
      return x;
   endfunction

   function automatic int cnt_width(input int w);
      int c;
      c = $clog2(w + 1);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Operand/result handshake bundle for serial_cmp_ctrl; slave is the comparator,
// master is the producer/consumer side.
interface serial_cmp_ctrl_if #(
   parameter int WIDTH = 5
);
   import cmp_pkg::*;

   localparam int CNT_W = cnt_width(WIDTH);

   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             res_valid;
   logic             res_ready;
   logic             gt;
   logic             eq;
   logic             lt;
   logic             busy;
   logic [CNT_W-1:0] bit_idx;

   modport slave (
      input  start_valid, a_in, b_in, res_ready,
      output start_ready, res_valid, gt, eq, lt, busy, bit_idx
   );

   modport master (
      output start_valid, a_in, b_in, res_ready,
      input  start_ready, res_valid, gt, eq, lt, busy, bit_idx
   );

endinterface

// File: rtl/serial_cmp_cell.sv
// One comparison cell: folds a single operand bit pair into the running compare state.
module serial_cmp_cell
   import cmp_pkg::*;
(
   input  logic       a_p,
   input  logic       b_p,
   input  cmp_state_e x_p,
   output cmp_state_e p_x
);

   always_comb begin
      p_x = cell_next(a_p, b_p, x_p);
   end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude comparator: one shared cell evaluated per clock, LSB to MSB,
// with registered GT/EQ/LT presented through a valid/ready result handshake.
module serial_cmp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic                clk,
   input  logic                reset_L,
   serial_cmp_ctrl_if.slave    bus
);

   localparam int              CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   fsm_state_e       state_q, state_d;
   cmp_state_e       cmp_q, cmp_d, cell_x;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CNT_W-1:0] idx_q, idx_d;

   serial_cmp_cell u_cell (
      .a_p (a_sh_q[0]),
      .b_p (b_sh_q[0]),
      .x_p (cmp_q),
      .p_x (cell_x)
   );

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q <= IDLE;
         cmp_q   <= EQ;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cmp_q   <= cmp_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmp_d   = cmp_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               a_sh_d  = bus.a_in;
               b_sh_d  = bus.b_in;
               cmp_d   = EQ;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cmp_d  = cell_x;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            // Counter stops on the MSB so bit_idx keeps its last processed index.
            if (idx_q == LAST) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.start_ready = (state_q == IDLE);
   assign bus.res_valid   = (state_q == DONE);
   assign bus.busy        = (state_q == RUN);
   assign bus.gt          = (state_q == DONE) && (cmp_q == GT);
   assign bus.eq          = (state_q == DONE) && (cmp_q == EQ);
   assign bus.lt          = (state_q == DONE) && (cmp_q == LT);
   assign bus.bit_idx     = idx_q;

endmodule
